// File: rtl/tick_prescaler.sv
// tick_prescaler: programmable falling-edge tick generator with periodic/one-shot, pause and restart.
module tick_prescaler #(
  parameter int BITS = 29
) (
  input  logic            NEclk,
  input  logic            Nreset,
  input  logic            start,
  input  logic            stop,
  input  logic            pause,
  input  logic            oneshot,
  input  logic [BITS-1:0] period,
  output logic            tick,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] phase
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [BITS-1:0] per;
  logic shot;
  logic wrap;
  assign wrap = phase == per - BITS'(1);
  always_ff @(negedge NEclk) begin
    if (!Nreset) begin
      state <= IDLE;
      phase <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      per   <= '0;
      shot  <= 1'b0;
    end else if (stop) begin
      state <= IDLE;
      phase <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else if (start) begin
      state <= RUN;
      phase <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b1;
      per   <= period == '0 ? BITS'(1) : period;
      shot  <= oneshot;
    end else if (state == IDLE) begin
      phase <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else if (pause) begin
      state <= PAUSE;
      tick  <= 1'b0;
      done  <= 1'b0;
    end else begin
      // a PAUSE edge with pause low counts exactly like a RUN edge
      phase <= wrap ? '0 : phase + BITS'(1);
      tick  <= wrap;
      done  <= wrap && shot;
      busy  <= !(wrap && shot);
      state <= wrap && shot ? IDLE : RUN;
    end
  end
endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: directed + randomized checks against an elapsed-edge reference model.
module tb_tick_prescaler;
  localparam int W = 8;
  logic NEclk = 1'b1;
  logic Nreset, start, stop, pause, oneshot;
  logic [W-1:0] period;
  logic tick, busy, done;
  logic [W-1:0] phase;
  int vectors = 0;
  int errs = 0;
  bit m_active = 0;
  bit m_shot = 0;
  bit m_tick = 0;
  bit m_done = 0;
  longint m_e = 0;
  longint m_p = 1;
  logic [W-1:0] m_phase;

  tick_prescaler #(.BITS(W)) dut (
    .NEclk(NEclk), .Nreset(Nreset), .start(start), .stop(stop), .pause(pause),
    .oneshot(oneshot), .period(period), .tick(tick), .busy(busy), .done(done), .phase(phase)
  );

  always #5 NEclk = ~NEclk;

  // model: count counting edges since start; ticks fall on multiples of P
  task automatic step(input bit rn, input bit st, input bit sp, input bit pa, input bit os, input int per_in);
    Nreset = rn; start = st; stop = sp; pause = pa; oneshot = os; period = W'(per_in);
    @(negedge NEclk);
    if (!rn || sp) begin
      m_active = 0; m_e = 0; m_tick = 0; m_done = 0;
    end else if (st) begin
      m_active = 1; m_e = 0; m_tick = 0; m_done = 0;
      m_p = (per_in == 0) ? 1 : per_in; m_shot = os;
    end else if (!m_active || pa) begin
      m_tick = 0; m_done = 0;
    end else begin
      m_e++;
      m_tick = (m_e % m_p) == 0;
      m_done = m_shot && m_tick;
      if (m_done) begin m_active = 0; m_e = 0; end
    end
    m_phase = m_active ? W'(m_e % m_p) : '0;
    #1;
    vectors++;
    assert (tick === m_tick) else begin errs++; $error("FAIL tick: got %0b expected %0b at vector %0d", tick, m_tick, vectors); end
    assert (done === m_done) else begin errs++; $error("FAIL done: got %0b expected %0b at vector %0d", done, m_done, vectors); end
    assert (busy === m_active) else begin errs++; $error("FAIL busy: got %0b expected %0b at vector %0d", busy, m_active, vectors); end
    assert (phase === m_phase) else begin errs++; $error("FAIL phase: got %0d expected %0d at vector %0d", phase, m_phase, vectors); end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 3);
    step(1, 1, 0, 0, 0, 3);
    idle(10);
    step(1, 1, 0, 0, 0, 0);
    idle(4);
    step(1, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 1, 0, 0, 1, 5);
    idle(8);
    step(1, 1, 0, 0, 0, 4);
    idle(1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    idle(9);
    step(1, 1, 0, 0, 0, 4);
    idle(1);
    step(1, 1, 0, 0, 0, 2);
    idle(5);
    step(1, 1, 0, 0, 0, 7);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 0, 2);
    step(1, 0, 0, 1, 0, 2);
    idle(7);
    step(1, 1, 1, 0, 0, 3);
    idle(3);
    step(1, 1, 0, 0, 0, 3);
    idle(1);
    step(0, 1, 0, 0, 0, 3);
    idle(5);
    step(1, 1, 0, 0, 0, 255);
    idle(520);
    step(1, 1, 0, 0, 1, 255);
    idle(258);
    for (int i = 0; i < 4000; i++) begin
      automatic int per_r = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 9));
      step($urandom_range(0, 199) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, per_r);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/tick_prescaler.md
# tick_prescaler

Programmable tick generator that sits directly upstream of the team's free-running event counters. It divides the falling-edge system clock by a run-time period and emits single-cycle `tick` pulses meant to drive a counter's `Enable` input. It supports periodic and one-shot modes, pause/resume and restart. Status outputs let the game controller sequence timed events.

## Interface
- `BITS`, default 29: width of `period` and `phase`; matches the downstream counter width.
- `NEclk` in 1: negative-edge clock; all state updates on the falling edge.
- `Nreset` in 1: reset, synchronous, active-low.
- `start` in 1: sampled each edge; starts or restarts a run and latches `period` and `oneshot`.
- `stop` in 1: sampled each edge; aborts the run and returns to IDLE.
- `pause` in 1: level; holds the run while high.
- `oneshot` in 1: mode, latched at start. 1 = single tick then stop; 0 = periodic.
- `period` in BITS: tick period P in clock cycles, latched at start. Value 0 is treated as 1.
- `tick` out 1: registered one-cycle pulse; connects to the counter's `Enable`.
- `busy` out 1: registered; high in RUN or PAUSE.
- `done` out 1: registered one-cycle pulse when a one-shot run completes.
- `phase` out BITS: registered; current position within the period.

## Operation
- FSM states: IDLE, RUN, PAUSE.
- Priority at each edge, highest first: `Nreset` low > `stop` > `start` > `pause` > normal counting.
- Reset or stop: state IDLE, `phase`=0, `tick`=0, `done`=0, `busy`=0. Latched period is cleared to 0 on reset only.
- Start, from any state:
  - state RUN, `phase`=0, `tick`=0;
  - latch P = max(`period`,1) and `oneshot`.
  - A start during RUN or PAUSE is a restart, and the previous phase is discarded.
- RUN edge with `pause` low:
  - if `phase`==P-1: `phase`=0, `tick`=1;
  - otherwise: `phase`=`phase`+1, `tick`=0.
- RUN edge with `pause` high: state PAUSE, `phase` held, `tick`=0. A pause on the would-tick edge suppresses that tick.
- PAUSE edge:
  - `pause` high: hold.
  - `pause` low: behaves exactly like a RUN counting edge and moves to RUN. No cycle is lost beyond the paused edges.
- One-shot: on the edge that produces `tick`=1, also set `done`=1 and state IDLE.
  - `busy` falls on that same edge.
  - `tick` and `done` are coincident, each for one cycle.
- IDLE with no start: all outputs 0. `start`/`stop`/`pause` asserted together with reset are ignored.
- `period` and `oneshot` changes during a run have no effect until the next start.
- Arithmetic is unsigned, BITS wide. `phase` never exceeds P-1, so there is no overflow. P = 2^BITS-1 is legal.

## Timing
- Start seen at edge k → `busy`=1 and `phase`=0 after edge k.
- First `tick` is high in the cycle after edge k+P. Subsequent ticks follow every P edges.
- P=1 (or `period`=0): `tick` stays high continuously from edge k+1 in periodic mode.
- Pause asserted for N consecutive edges delays every subsequent tick by exactly N edges.
- `stop` at edge m: `tick` and `busy` are 0 after edge m, even if edge m would have ticked.
- Reset mid-run: all outputs 0 after the reset edge, independent of state.
- No combinational path from any input to any output.

## Test plan
- Reset; start with `period`=3, `oneshot`=0 at edge 0 → `tick` high after edges 3, 6, 9; `phase` sequence 0,1,2,0,1,2; `busy`=1 throughout.
- `period`=0, periodic start → `tick` high every cycle from edge 1. Then `stop` → `tick`=0 and `busy`=0 on the following cycle.
- `oneshot`=1, `period`=5, start at edge 0 → `tick`=`done`=1 for exactly one cycle after edge 5; `busy`=0 from edge 5; no further ticks.
- `period`=4, start at edge 0, `pause` high on edges 2–4 → `phase` frozen at 1; first tick after edge 7; next after edge 11.
- `period`=4, restart at edge 2 with `period`=2 → `phase`=0 after edge 2; ticks after edges 4, 6.
- Simultaneous `start`+`stop` → IDLE. `Nreset` low mid-run with `start` high → all outputs 0; no run begins until a start after reset is released.
